avg_unpool: RTL and testbench
=============================

Name: avg_unpool

Overview:
- Inverse of the 2x2 average-pool stage.
- Accepts one TILE_W x TILE_W tile whose four POOL_W x POOL_W quadrants (sub_block 0..3) each hold a pooled map.
- Emits, one per handshake, a full TILE_W x TILE_W nearest-neighbour upsampled tile per quadrant, tagged with its sub_block.
- Sits between the pooled-tile buffer and the DDR3 write-back path, which may stall.

Parameters:
- TILE_W, 8, tile edge in pixels (even); POOL_W = TILE_W/2 is a localparam.
- PIX_W, 32, pixel width in bits (unsigned).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  pixels_in holds a valid pooled tile
- in_ready  output  1  block can capture a tile
- pixels_in  input  [TILE_W*TILE_W-1:0][PIX_W-1:0]  pooled tile; pixel index = row*TILE_W + col
- out_valid  output  1  pixels_out/out_sub_block/out_last valid
- out_ready  input  1  downstream accepts output
- pixels_out  output  [TILE_W*TILE_W-1:0][PIX_W-1:0]  upsampled tile, same indexing
- out_sub_block  output  2  source quadrant of current output
- out_last  output  1  current output is the final one for this input tile
- busy  output  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n; asserting it clears all state immediately.
- Reset values: state=IDLE, in_ready=1, out_valid=0, pixels_out=0, out_sub_block=0, out_last=0, busy=0, tile register=0.
- Reset mid-operation: in-flight tile is discarded and no partial output is completed.
- Quadrant mapping: quadrant q has qr=q[1] and qc=q[0].
  - q=0: rows 0..3, cols 0..3. q=1: rows 0..3, cols 4..7.
  - q=2: rows 4..7, cols 0..3. q=3: rows 4..7, cols 4..7.
- Upsample: pixels_out[r*TILE_W+c] = tile[(qr*POOL_W + r/2)*TILE_W + qc*POOL_W + c/2] for all r,c in 0..TILE_W-1.
  - Pure replication, no arithmetic, no width change.
- States: IDLE, LOAD, EMIT.
- IDLE: in_ready=1.
  - On in_valid&&in_ready, register pixels_in and go to LOAD.
  - in_ready drops the following cycle.
- LOAD (1 cycle):
  - Select the first quadrant to emit and register pixels_out/out_sub_block/out_last for it.
  - Go to EMIT, with out_valid=1 from the next cycle.
  - Latency from input accept to first out_valid is 2 cycles.
- EMIT: out_valid=1.
  - While out_valid && !out_ready, all outputs hold stable.
  - On a handshake with out_last=0: pixels_out/out_sub_block/out_last update to the next quadrant on the same edge, so out_valid stays high and there is no bubble. Throughput is 1 tile/cycle when out_ready stays high.
  - On a handshake with out_last=1: out_valid=0 and go to IDLE. in_ready=1 the next cycle; there is no overlap of capture and emission.
- in_valid during LOAD/EMIT is ignored (in_ready=0). Upstream must hold the tile.
- Quadrants are emitted in ascending order 0,1,2,3. out_last=1 only with the final emitted quadrant.
- out_ready asserted while out_valid=0 has no effect.

Optional Feature:
- Macro: AVG_UNPOOL_SKIP_ZERO_EN.
- Defined:
  - At capture, compute a 4-bit mask of quadrants whose POOL_W*POOL_W source pixels are all zero.
  - Such quadrants are never emitted; emission jumps directly to the next non-zero quadrant with no idle cycle.
  - out_last marks the highest non-zero quadrant.
  - If all four quadrants are zero: LOAD returns straight to IDLE, out_valid never asserts, and in_ready=1 two cycles after acceptance.
- Undefined: all four quadrants are always emitted, and no zero-detect logic exists.

Test Plan:
- Reset then idle: rst_n low, then high -> in_ready=1, out_valid=0, pixels_out all 0, busy=0.
- Tile with pixel[i]=i, out_ready=1 -> out_valid at cycle 2 after accept, then 4 consecutive outputs with sub_block 0,1,2,3.
  - Quadrant 0 output pixel[9] (r1,c1) = 0; pixel[18] (r2,c2) = 9.
  - Quadrant 3 output pixel[0] = 36; pixel[63] = 63.
  - out_last=1 only on quadrant 3.
- Backpressure: out_ready low 5 cycles during quadrant 1 -> pixels_out/out_sub_block stable; on release, quadrant 2 follows with no bubble.
- in_valid held high during EMIT with a different tile -> ignored; the second tile is accepted only in the cycle after out_last handshake.
- Async reset asserted mid-EMIT at quadrant 2 -> out_valid=0 and pixels_out=0 immediately (no clock edge needed); after release the block is in IDLE.
- With AVG_UNPOOL_SKIP_ZERO_EN and quadrants 1,3 all zero -> only sub_block 0 then 2 emitted, with out_last on 2. An all-zero tile -> no out_valid, and in_ready=1 two cycles after accept.

Source files
------------

// File: rtl/avg_unpool.sv
// avg_unpool: inverse of the 2x2 average-pool stage.
//
// Captures one TILE_W x TILE_W tile whose four POOL_W x POOL_W quadrants
// each hold a pooled map, then emits one nearest-neighbour upsampled
// TILE_W x TILE_W tile per quadrant (ascending sub_block order), one per
// output handshake, with no bubble between quadrants.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        input tile handshake (pixels_in)
//   pixels_in                  pooled tile, index = row*TILE_W + col
//   out_valid / out_ready      output handshake
//   pixels_out                 upsampled tile, same indexing
//   out_sub_block              source quadrant of the current output
//   out_last                   final output for the captured tile
//   busy                       block is not idle
//
// Optional feature macro: AVG_UNPOOL_SKIP_ZERO_EN
//   When defined, quadrants whose source pixels are all zero are skipped;
//   an all-zero tile produces no output at all.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a tile, in_ready=1
// LOAD  | tile captured, first quadrant being registered
// EMIT  | out_valid=1, stepping through quadrants on each handshake

module avg_unpool #(
    parameter int TILE_W = 8,
    parameter int PIX_W  = 32
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [TILE_W*TILE_W-1:0][PIX_W-1:0]   pixels_in,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [TILE_W*TILE_W-1:0][PIX_W-1:0]   pixels_out,
    output logic [1:0]                            out_sub_block,
    output logic                                  out_last,
    output logic                                  busy
);

    localparam int POOL_W = TILE_W / 2;
    localparam int NPIX   = TILE_W * TILE_W;

    typedef logic [NPIX-1:0][PIX_W-1:0] tile_t;
    typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;

    state_t      state_q, state_d;
    tile_t       tile_q, tile_d;
    tile_t       pixels_out_q, pixels_out_d;
    logic [1:0]  sub_block_q, sub_block_d;
    logic        last_q, last_d;

    // Each output pixel (r,c) copies source pixel (r/2, c/2) of quadrant q.
    function automatic tile_t upsample(input tile_t t, input logic [1:0] q);
        tile_t o;
        int    base_r;
        int    base_c;
        base_r = q[1] ? POOL_W : 0;
        base_c = q[0] ? POOL_W : 0;
        o = '0;
        for (int r = 0; r < TILE_W; r++) begin
            for (int c = 0; c < TILE_W; c++) begin
                o[r*TILE_W + c] = t[(base_r + r/2)*TILE_W + base_c + c/2];
            end
        end
        return o;
    endfunction

`ifdef AVG_UNPOOL_SKIP_ZERO_EN
    logic [3:0] nz_q, nz_d;

    // Bit q set when quadrant q holds at least one non-zero pixel.
    function automatic logic [3:0] nonzero_mask(input tile_t t);
        logic [3:0] m;
        m = '0;
        for (int q = 0; q < 4; q++) begin
            for (int r = 0; r < POOL_W; r++) begin
                for (int c = 0; c < POOL_W; c++) begin
                    if (t[((q/2)*POOL_W + r)*TILE_W + (q%2)*POOL_W + c] != '0) begin
                        m[q] = 1'b1;
                    end
                end
            end
        end
        return m;
    endfunction

    function automatic logic [1:0] lowest_set(input logic [3:0] m);
        logic [1:0] v;
        v = '0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) v = i[1:0];
        end
        return v;
    endfunction

    function automatic logic [3:0] above(input logic [1:0] q);
        logic [3:0] a;
        for (int i = 0; i < 4; i++) begin
            a[i] = (i > int'(q));
        end
        return a;
    endfunction
`endif

    logic [1:0] first_q, next_q, sel_q;
    logic       first_last, next_last, sel_last;

    always_comb begin
`ifdef AVG_UNPOOL_SKIP_ZERO_EN
        first_q    = lowest_set(nz_q);
        first_last = (nz_q & above(first_q)) == 4'b0000;
        next_q     = lowest_set(nz_q & above(sub_block_q));
        next_last  = (nz_q & above(next_q)) == 4'b0000;
`else
        first_q    = 2'd0;
        first_last = 1'b0;
        next_q     = sub_block_q + 2'd1;
        next_last  = (sub_block_q == 2'd2);
`endif
        sel_q    = (state_q == LOAD) ? first_q : next_q;
        sel_last = (state_q == LOAD) ? first_last : next_last;
    end

    always_comb begin
        state_d      = state_q;
        tile_d       = tile_q;
        pixels_out_d = pixels_out_q;
        sub_block_d  = sub_block_q;
        last_d       = last_q;
`ifdef AVG_UNPOOL_SKIP_ZERO_EN
        nz_d         = nz_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    tile_d  = pixels_in;
`ifdef AVG_UNPOOL_SKIP_ZERO_EN
                    nz_d    = nonzero_mask(pixels_in);
`endif
                    state_d = LOAD;
                end
            end
            LOAD: begin
                pixels_out_d = upsample(tile_q, sel_q);
                sub_block_d  = sel_q;
                last_d       = sel_last;
                state_d      = EMIT;
`ifdef AVG_UNPOOL_SKIP_ZERO_EN
                if (nz_q == 4'b0000) state_d = IDLE;
`endif
            end
            EMIT: begin
                if (out_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                    end else begin
                        // Next quadrant is loaded on the handshake edge: no bubble.
                        pixels_out_d = upsample(tile_q, sel_q);
                        sub_block_d  = sel_q;
                        last_d       = sel_last;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            tile_q       <= '0;
            pixels_out_q <= '0;
            sub_block_q  <= '0;
            last_q       <= 1'b0;
`ifdef AVG_UNPOOL_SKIP_ZERO_EN
            nz_q         <= '0;
`endif
        end else begin
            state_q      <= state_d;
            tile_q       <= tile_d;
            pixels_out_q <= pixels_out_d;
            sub_block_q  <= sub_block_d;
            last_q       <= last_d;
`ifdef AVG_UNPOOL_SKIP_ZERO_EN
            nz_q         <= nz_d;
`endif
        end
    end

    assign in_ready      = (state_q == IDLE);
    assign out_valid     = (state_q == EMIT);
    assign busy          = (state_q != IDLE);
    assign pixels_out    = pixels_out_q;
    assign out_sub_block = sub_block_q;
    assign out_last      = last_q;

endmodule

// File: tb/tb_avg_unpool.sv
// Testbench for avg_unpool: randomized tiles and output backpressure,
// checked against a behavioural model of the quadrant upsample and the
// emission order (optionally skipping all-zero quadrants).

module tb_avg_unpool;

    localparam int TW   = 8;
    localparam int PW   = TW / 2;
    localparam int PIXW = 32;
    localparam int NPIX = TW * TW;

    typedef logic [NPIX-1:0][PIXW-1:0] tile_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    tile_t       pixels_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    tile_t       pixels_out;
    logic [1:0]  out_sub_block;
    logic        out_last;
    logic        busy;

    int checks = 0;
    int errors = 0;

    avg_unpool #(.TILE_W(TW), .PIX_W(PIXW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .pixels_in     (pixels_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .pixels_out    (pixels_out),
        .out_sub_block (out_sub_block),
        .out_last      (out_last),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: output (r,c) of quadrant q is source row q/2*PW + r/2,
    // source column q%2*PW + c/2.
    function automatic logic [PIXW-1:0] ref_pix(input tile_t src, input int q, input int idx);
        int r, c;
        r = idx / TW;
        c = idx % TW;
        return src[((q / 2) * PW + r / 2) * TW + (q % 2) * PW + c / 2];
    endfunction

    function automatic int pix_errs(input tile_t got, input tile_t src, input int q);
        int n = 0;
        for (int i = 0; i < NPIX; i++) if (got[i] !== ref_pix(src, q, i)) n++;
        return n;
    endfunction

    function automatic int quad_of(input int idx);
        return ((idx / TW) / PW) * 2 + (idx % TW) / PW;
    endfunction

    function automatic bit quad_zero(input tile_t t, input int q);
        bit z = 1'b1;
        for (int i = 0; i < NPIX; i++) if (quad_of(i) == q && t[i] != '0) z = 1'b0;
        return z;
    endfunction

    function automatic int nonzero_count(input tile_t t);
        int n = 0;
        for (int i = 0; i < NPIX; i++) if (t[i] !== '0) n++;
        return n;
    endfunction

    function automatic tile_t rand_tile();
        tile_t t;
        bit    zq[4];
        for (int q = 0; q < 4; q++) zq[q] = ($urandom_range(3) == 0);
        for (int i = 0; i < NPIX; i++) t[i] = zq[quad_of(i)] ? '0 : PIXW'($urandom);
        return t;
    endfunction

    // Drives one tile, runs it to completion against the model.
    // stall_pct < 0 selects the directed 5-cycle stall on quadrant 1.
    task automatic process_tile(input tile_t t, input int stall_pct, input bit hold_second,
                                input tile_t t2, output int accept_wait, output tile_t snap0,
                                output tile_t snap3);
        int exp_q[$];
        int w;
        int cyc;
        int stalled;
        bit rdy;
        bit hs;
        snap0 = '0;
        snap3 = '0;
        for (int q = 0; q < 4; q++) begin
`ifdef AVG_UNPOOL_SKIP_ZERO_EN
            if (!quad_zero(t, q)) exp_q.push_back(q);
`else
            exp_q.push_back(q);
`endif
        end
        pixels_in = t;
        in_valid  = 1'b1;
        w = 0;
        do begin
            rdy = in_ready;
            @(posedge clk); #1;
            w++;
        end while (!rdy && w < 50);
        if (!rdy) chk("accept_timeout", 0, 1);
        accept_wait = w - 1;
        if (hold_second) pixels_in = t2;
        else in_valid = 1'b0;

        chk("load_valid", out_valid, 0);
        chk("load_in_ready", in_ready, 0);
        chk("load_busy", busy, 1);
        cyc = 1;
        stalled = 0;
        while (exp_q.size() > 0 && cyc < 200) begin
            if (cyc >= 2) begin
                chk("out_valid", out_valid, 1);
                chk("emit_in_ready", in_ready, 0);
                if (out_valid) begin
                    chk("sub_block", out_sub_block, exp_q[0]);
                    chk("out_last", out_last, exp_q.size() == 1);
                    chk("pixels", pix_errs(pixels_out, t, exp_q[0]), 0);
                    if (exp_q[0] == 0) snap0 = pixels_out;
                    if (exp_q[0] == 3) snap3 = pixels_out;
                end
            end
            if (stall_pct < 0) begin
                out_ready = !(out_valid && exp_q[0] == 1 && stalled < 5);
                if (!out_ready && out_valid) stalled++;
            end else begin
                out_ready = !($urandom_range(99) < stall_pct);
            end
            hs = out_valid && out_ready;
            @(posedge clk); #1;
            if (hs) void'(exp_q.pop_front());
            cyc++;
        end
        if (exp_q.size() > 0) chk("emit_timeout", 0, 1);
        if (cyc == 1) begin
            out_ready = 1'($urandom_range(1));
            @(posedge clk); #1;
        end
        if (stall_pct < 0) chk("stall_cycles", stalled, 5);
        chk("idle_in_ready", in_ready, 1);
        chk("idle_out_valid", out_valid, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        tile_t t, t2, s0, s3;
        int    w;
        bit    reached;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sub_block", out_sub_block, 0);
        chk("rst_last", out_last, 0);
        chk("rst_pixels_nz", nonzero_count(pixels_out), 0);

        // Ramp tile, full throughput.
        for (int i = 0; i < NPIX; i++) t[i] = PIXW'(i);
        process_tile(t, 0, 1'b0, '0, w, s0, s3);
        chk("ramp_q0_p9", s0[9], 0);
        chk("ramp_q0_p18", s0[18], 9);
        chk("ramp_q3_p0", s3[0], 36);
        chk("ramp_q3_p63", s3[63], 63);

        // Backpressure: 5 stall cycles while quadrant 1 is presented.
        for (int i = 0; i < NPIX; i++) t[i] = PIXW'($urandom) | 32'h1;
        process_tile(t, -1, 1'b0, '0, w, s0, s3);

        // Second tile held on the input during emission of the first.
        for (int i = 0; i < NPIX; i++) t[i] = PIXW'($urandom) | 32'h1;
        for (int i = 0; i < NPIX; i++) t2[i] = PIXW'($urandom) | 32'h1;
        process_tile(t, 20, 1'b1, t2, w, s0, s3);
        process_tile(t2, 0, 1'b0, '0, w, s0, s3);
        chk("second_accept_wait", w, 0);

        // Quadrants 1 and 3 all zero, then an all-zero tile.
        for (int i = 0; i < NPIX; i++)
            t[i] = (quad_of(i) == 1 || quad_of(i) == 3) ? '0 : (PIXW'($urandom) | 32'h1);
        process_tile(t, 30, 1'b0, '0, w, s0, s3);
        process_tile('0, 0, 1'b0, '0, w, s0, s3);

        for (int n = 0; n < 20; n++) begin
            process_tile(rand_tile(), int'($urandom_range(60)), 1'b0, '0, w, s0, s3);
        end

        // Asynchronous reset while quadrant 2 is presented.
        for (int i = 0; i < NPIX; i++) t[i] = PIXW'($urandom) | 32'h1;
        pixels_in = t;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        reached = 1'b0;
        for (int k = 0; k < 20 && !reached; k++) begin
            if (out_valid && out_sub_block == 2'd2) reached = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk("rst_reach_q2", reached, 1);
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_pixels_nz", nonzero_count(pixels_out), 0);
        chk("arst_sub_block", out_sub_block, 0);
        chk("arst_last", out_last, 0);
        chk("arst_busy", busy, 0);
        chk("arst_in_ready", in_ready, 1);
        #10 rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("post_rst_valid", out_valid, 0);
            chk("post_rst_busy", busy, 0);
        end

        process_tile(rand_tile(), 25, 1'b0, '0, w, s0, s3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
